// File: rtl/pwm_sequencer.sv
// Plays a table of (duty, dwell) steps into a PWM duty input, holding each
// step for a dwell counted in PWM periods; supports one-shot, looped playback and abort.
module pwm_sequencer #(
    parameter int ADDR_W  = 3,
    parameter int DWELL_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [7:0]         cfg_duty,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [ADDR_W-1:0]  last_step,
    input  logic               loop_en,
    input  logic               start,
    input  logic               stop,
    input  logic               rollover,
    output logic [7:0]         duty_cycle,
    output logic               pwm_en,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  step_idx
);

    localparam int STEPS = 2**ADDR_W;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [7:0]         duty_tab  [STEPS];
    logic [DWELL_W-1:0] dwell_tab [STEPS];

    logic [7:0]         duty_q, duty_d;
    logic [DWELL_W-1:0] lim_q, lim_d;
    logic [DWELL_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0]  step_q, step_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic               done_q, done_d;
    logic               load_en;
    logic [ADDR_W-1:0]  load_idx;

    // lim holds the terminal count max(dwell,1)-1, so dwell 0 behaves as 1.
    function automatic logic [DWELL_W-1:0] lim_of(input logic [DWELL_W-1:0] dwell);
        return (dwell == '0) ? '0 : dwell - DWELL_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                duty_tab[i]  <= '0;
                dwell_tab[i] <= '0;
            end
        end else if (cfg_we) begin
            duty_tab[cfg_addr]  <= cfg_duty;
            dwell_tab[cfg_addr] <= cfg_dwell;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            lim_q   <= '0;
            count_q <= '0;
            step_q  <= '0;
            last_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            lim_q   <= lim_d;
            count_q <= count_d;
            step_q  <= step_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        lim_d    = lim_q;
        count_d  = count_q;
        step_d   = step_q;
        last_d   = last_q;
        done_d   = 1'b0;
        load_en  = 1'b0;
        load_idx = '0;

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d  = RUN;
                    last_d   = last_step;
                    load_en  = 1'b1;
                    load_idx = '0;
                end
            end
            RUN: begin
                // Abort outranks a step completing in the same cycle.
                if (stop) begin
                    state_d = IDLE;
                    duty_d  = '0;
                    lim_d   = '0;
                    count_d = '0;
                    step_d  = '0;
                end else if (rollover) begin
                    if (count_q == lim_q) begin
                        if (step_q != last_q) begin
                            load_en  = 1'b1;
                            load_idx = step_q + ADDR_W'(1);
                        end else if (loop_en) begin
                            load_en  = 1'b1;
                            load_idx = '0;
                        end else begin
                            state_d = IDLE;
                            duty_d  = '0;
                            lim_d   = '0;
                            count_d = '0;
                            step_d  = '0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q + DWELL_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            step_d  = load_idx;
            duty_d  = duty_tab[load_idx];
            lim_d   = lim_of(dwell_tab[load_idx]);
            count_d = '0;
        end
    end

    assign busy       = (state_q == RUN);
    assign pwm_en     = busy;
    assign duty_cycle = duty_q;
    assign step_idx   = step_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Self-checking bench for pwm_sequencer: a period-level reference model expands
// the table into the expected duty/step sequence, one entry per PWM period.
module tb_pwm_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = '0;
    logic [7:0] cfg_duty = '0;
    logic [9:0] cfg_dwell = '0;
    logic [2:0] last_step = '0;
    logic       loop_en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       rollover = 1'b0;
    logic [7:0] duty_cycle;
    logic       pwm_en;
    logic       busy;
    logic       done;
    logic [2:0] step_idx;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [2:0] idx_q[$];
    logic [7:0] m_duty[8];
    logic [9:0] m_dwell[8];

    pwm_sequencer #(.ADDR_W(3), .DWELL_W(10)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_duty(cfg_duty), .cfg_dwell(cfg_dwell), .last_step(last_step),
        .loop_en(loop_en), .start(start), .stop(stop), .rollover(rollover),
        .duty_cycle(duty_cycle), .pwm_en(pwm_en), .busy(busy), .done(done),
        .step_idx(step_idx)
    );

    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg_write(input int a, input logic [7:0] d, input logic [9:0] w);
        cfg_we    = 1'b1;
        cfg_addr  = a[2:0];
        cfg_duty  = d;
        cfg_dwell = w;
        tick();
        cfg_we = 1'b0;
        m_duty[a]  = d;
        m_dwell[a] = w;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_roll(input int gap);
        repeat (gap) tick();
        rollover = 1'b1;
        tick();
        rollover = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Reference model: one expected (duty, step) pair per PWM period of a pass.
    task automatic build_pass(input int last);
        int n;
        exp_q.delete();
        idx_q.delete();
        for (int s = 0; s <= last; s++) begin
            n = (m_dwell[s] == 0) ? 1 : int'(m_dwell[s]);
            for (int k = 0; k < n; k++) begin
                exp_q.push_back(m_duty[s]);
                idx_q.push_back(3'(s));
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        checks++;
        if ({busy, pwm_en, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got busy/pwm_en/done=%b expected 000", {busy, pwm_en, done});
        end
        checks++;
        if (duty_cycle !== 8'h00 || step_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: got duty=%h step=%0d expected 00/0", duty_cycle, step_idx);
        end
    endtask

    task automatic test_reset_mid_run();
        cfg_write(0, 8'h80, 10'd2);
        last_step = 3'd0;
        loop_en   = 1'b0;
        pulse_start();
        checks++;
        if (duty_cycle !== 8'h80 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_prerun: got duty=%h busy=%b expected 80/1", duty_cycle, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (duty_cycle !== 8'h00 || busy !== 1'b0 || pwm_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: got duty=%h busy=%b pwm_en=%b expected 00/0/0", duty_cycle, busy, pwm_en);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_duty[i]  = '0;
            m_dwell[i] = '0;
        end
        tick();
        pulse_start();
        checks++;
        if (duty_cycle !== 8'h00 || busy !== 1'b1 || step_idx !== 3'd0) begin
            errors++;
            $display("FAIL rst_table_clear: got duty=%h busy=%b step=%0d expected 00/1/0", duty_cycle, busy, step_idx);
        end
        do_stop();
    endtask

    task automatic test_oneshot();
        cfg_write(0, 8'h10, 10'd2);
        cfg_write(1, 8'h80, 10'd1);
        cfg_write(2, 8'hF0, 10'd3);
        last_step = 3'd2;
        loop_en   = 1'b0;
        build_pass(2);
        pulse_start();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (duty_cycle !== exp_q[i] || step_idx !== idx_q[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_period%0d: got duty=%h step=%0d busy=%b expected %h/%0d/1",
                         i, duty_cycle, step_idx, busy, exp_q[i], idx_q[i]);
            end
            pulse_roll($urandom_range(0, 2));
        end
        checks++;
        if (done !== 1'b1 || duty_cycle !== 8'h00 || busy !== 1'b0 || pwm_en !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_done: got done=%b duty=%h busy=%b pwm_en=%b expected 1/00/0/0",
                     done, duty_cycle, busy, pwm_en);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_done_width: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_loop();
        loop_en = 1'b1;
        build_pass(2);
        pulse_start();
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (duty_cycle !== exp_q[i] || step_idx !== idx_q[i]) begin
                errors++;
                $display("FAIL loop1_period%0d: got duty=%h step=%0d expected %h/%0d",
                         i, duty_cycle, step_idx, exp_q[i], idx_q[i]);
            end
            pulse_roll($urandom_range(0, 2));
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL loop1_no_done%0d: got done=%b expected 0", i, done);
            end
        end
        checks++;
        if (duty_cycle !== m_duty[0] || step_idx !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL loop_wrap: got duty=%h step=%0d busy=%b expected %h/0/1",
                     duty_cycle, step_idx, busy, m_duty[0]);
        end
        loop_en = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (duty_cycle !== exp_q[i] || step_idx !== idx_q[i]) begin
                errors++;
                $display("FAIL loop2_period%0d: got duty=%h step=%0d expected %h/%0d",
                         i, duty_cycle, step_idx, exp_q[i], idx_q[i]);
            end
            pulse_roll($urandom_range(0, 2));
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || duty_cycle !== 8'h00) begin
            errors++;
            $display("FAIL loop_end_done: got done=%b busy=%b duty=%h expected 1/0/00", done, busy, duty_cycle);
        end
        tick();
    endtask

    task automatic test_stop_priority();
        pulse_start();
        pulse_roll(1);
        pulse_roll(0);
        checks++;
        if (step_idx !== 3'd1 || duty_cycle !== 8'h80) begin
            errors++;
            $display("FAIL stop_setup: got step=%0d duty=%h expected 1/80", step_idx, duty_cycle);
        end
        rollover = 1'b1;
        stop     = 1'b1;
        tick();
        rollover = 1'b0;
        stop     = 1'b0;
        checks++;
        if (busy !== 1'b0 || pwm_en !== 1'b0 || duty_cycle !== 8'h00 || done !== 1'b0 || step_idx !== 3'd0) begin
            errors++;
            $display("FAIL stop_abort: got busy=%b pwm_en=%b duty=%h done=%b step=%0d expected 0/0/00/0/0",
                     busy, pwm_en, duty_cycle, done, step_idx);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_no_done: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_dwell0_and_live_write();
        cfg_write(0, 8'h20, 10'd0);
        cfg_write(1, 8'h30, 10'd1);
        last_step = 3'd1;
        loop_en   = 1'b1;
        pulse_start();
        checks++;
        if (duty_cycle !== 8'h20) begin
            errors++;
            $display("FAIL live_start: got duty=%h expected 20", duty_cycle);
        end
        cfg_write(0, 8'h55, 10'd0);
        checks++;
        if (duty_cycle !== 8'h20 || step_idx !== 3'd0) begin
            errors++;
            $display("FAIL live_write_hold: got duty=%h step=%0d expected 20/0", duty_cycle, step_idx);
        end
        pulse_roll(1);
        checks++;
        if (duty_cycle !== 8'h30 || step_idx !== 3'd1) begin
            errors++;
            $display("FAIL dwell0_advance: got duty=%h step=%0d expected 30/1", duty_cycle, step_idx);
        end
        pulse_roll(0);
        checks++;
        if (duty_cycle !== 8'h55 || step_idx !== 3'd0) begin
            errors++;
            $display("FAIL live_write_next_loop: got duty=%h step=%0d expected 55/0", duty_cycle, step_idx);
        end
        do_stop();
        loop_en = 1'b0;
    endtask

    task automatic test_start_rules();
        cfg_write(0, 8'h10, 10'd2);
        cfg_write(1, 8'h80, 10'd1);
        last_step = 3'd1;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        checks++;
        if (busy !== 1'b0 || pwm_en !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_idle: got busy=%b pwm_en=%b expected 0/0", busy, pwm_en);
        end
        pulse_start();
        pulse_roll(0);
        start = 1'b1;
        repeat (3) tick();
        checks++;
        if (step_idx !== 3'd0 || duty_cycle !== 8'h10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_in_run: got step=%0d duty=%h busy=%b expected 0/10/1", step_idx, duty_cycle, busy);
        end
        pulse_roll(0);
        start = 1'b0;
        checks++;
        if (step_idx !== 3'd1 || duty_cycle !== 8'h80) begin
            errors++;
            $display("FAIL start_keeps_count: got step=%0d duty=%h expected 1/80", step_idx, duty_cycle);
        end
        do_stop();
    endtask

    task automatic test_relaunch();
        cfg_write(0, 8'h44, 10'd1);
        last_step = 3'd0;
        loop_en   = 1'b0;
        start     = 1'b1;
        tick();
        pulse_roll(0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL relaunch_done: got done=%b busy=%b expected 1/0", done, busy);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || duty_cycle !== 8'h44 || done !== 1'b0) begin
            errors++;
            $display("FAIL relaunch_run: got busy=%b duty=%h done=%b expected 1/44/0", busy, duty_cycle, done);
        end
        do_stop();
    endtask

    task automatic test_random();
        int last;
        for (int it = 0; it < 5; it++) begin
            for (int a = 0; a < 8; a++)
                cfg_write(a, 8'($urandom_range(0, 255)), 10'($urandom_range(0, 3)));
            last      = $urandom_range(0, 7);
            last_step = 3'(last);
            loop_en   = 1'b0;
            build_pass(last);
            pulse_start();
            last_step = 3'($urandom_range(0, 7));
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (duty_cycle !== exp_q[i] || step_idx !== idx_q[i] || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL rand%0d_period%0d: got duty=%h step=%0d busy=%b expected %h/%0d/1",
                             it, i, duty_cycle, step_idx, busy, exp_q[i], idx_q[i]);
                end
                pulse_roll($urandom_range(0, 2));
            end
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || duty_cycle !== 8'h00) begin
                errors++;
                $display("FAIL rand%0d_done: got done=%b busy=%b duty=%h expected 1/0/00", it, done, busy, duty_cycle);
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_duty[i]  = '0;
            m_dwell[i] = '0;
        end
        tick();
        test_reset();
        tick();
        rst = 1'b0;
        tick();
        test_reset();
        test_reset_mid_run();
        test_oneshot();
        test_loop();
        test_stop_priority();
        test_dwell0_and_live_write();
        test_start_rules();
        test_relaunch();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
